// File: rtl/divider_unit.sv
// rtl/divider_unit.sv - multi-cycle restoring divider for DIV/DIVU/REM/REMU
// Optional: DIVIDER_EARLY_OUT_EN sends divide-by-zero and signed overflow straight to DONE.
module divider_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y
);
    localparam int W  = WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   a_l, b_l;
    logic [1:0]     op_l;
    logic [2*W:0]   acc;
    logic [CW-1:0]  cnt;

    logic           accept;
    logic           early;
    logic [W-1:0]   amag_in, bmag;
    logic [2*W:0]   shifted, step;
    logic [W+1:0]   trial;
    logic [W-1:0]   q, r, fix_y;
    logic           neg_q, neg_r;

    assign accept = start && (state == IDLE || state == DONE);

`ifdef DIVIDER_EARLY_OUT_EN
    logic         special_in;
    logic [W-1:0] special_y;
    assign special_in = (b == '0) ||
                        (!op[0] && a == {1'b1, {(W-1){1'b0}}} && b == '1);
    // quotient: all ones for /0, a for overflow; remainder: a for /0, 0 for overflow
    assign special_y  = (b == '0) ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    assign early      = special_in;
`else
    assign early      = 1'b0;
`endif

    // magnitudes: negating the most-negative value yields 2^(W-1) as unsigned, as needed
    assign amag_in = (!op[0] && a[W-1]) ? (~a + 1'b1) : a;
    assign bmag    = (!op_l[0] && b_l[W-1]) ? (~b_l + 1'b1) : b_l;

    // acc = {partial remainder (W+1 bits), dividend/quotient (W bits)}
    assign shifted = acc << 1;
    assign trial   = {1'b0, shifted[2*W:W]} - {2'b00, bmag};
    assign step    = trial[W+1] ? shifted : {trial[W:0], shifted[W-1:1], 1'b1};

    assign q     = acc[W-1:0];
    assign r     = acc[2*W-1:W];
    assign neg_q = !op_l[0] && (a_l[W-1] ^ b_l[W-1]);
    assign neg_r = !op_l[0] && a_l[W-1];

    always_comb begin
        fix_y = '0;
        if (b_l == '0)
            fix_y = op_l[1] ? a_l : '1;
        else if (op_l[1])
            fix_y = neg_r ? (~r + 1'b1) : r;
        else
            fix_y = neg_q ? (~q + 1'b1) : q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = early ? DONE : RUN;
            RUN:  if (cnt == CW'(W-1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = start ? (early ? DONE : RUN) : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_l  <= '0;
            b_l  <= '0;
            op_l <= '0;
            acc  <= '0;
            cnt  <= '0;
            y    <= '0;
        end else if (accept) begin
            a_l  <= a;
            b_l  <= b;
            op_l <= op;
            acc  <= {{(W+1){1'b0}}, amag_in};
            cnt  <= '0;
`ifdef DIVIDER_EARLY_OUT_EN
            if (special_in)
                y <= special_y;
`endif
        end else if (state == RUN) begin
            acc <= step;
            cnt <= cnt + CW'(1);
        end else if (state == FIX) begin
            y <= fix_y;
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// tb/tb_divider_unit.sv - randomized self-checking bench for divider_unit
module tb_divider_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] y;

    int n_cmp = 0;
    int n_err = 0;

    divider_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .y(y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics, computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_y(input logic [1:0] o, input logic [31:0] x, input logic [31:0] d);
        longint sx, sd, res;
        logic [63:0] ux, ud, ures;
        logic [63:0] rv;
        sx = longint'($signed(x));
        sd = longint'($signed(d));
        ux = {32'd0, x};
        ud = {32'd0, d};
        rv = 64'd0;
        case (o)
            2'b00: if (d == 0) rv = 64'hFFFF_FFFF; else begin res = sx / sd; rv = res; end
            2'b01: if (d == 0) rv = 64'hFFFF_FFFF; else begin ures = ux / ud; rv = ures; end
            2'b10: if (d == 0) rv = ux; else begin res = sx % sd; rv = res; end
            default: if (d == 0) rv = ux; else begin ures = ux % ud; rv = ures; end
        endcase
        return rv[31:0];
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] d);
`ifdef DIVIDER_EARLY_OUT_EN
        if (d == 0 || (!o[0] && x == 32'h8000_0000 && d == 32'hFFFF_FFFF))
            return 0;
`endif
        return 33;
    endfunction

    // latency counts edges after the acceptance edge until done is seen
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] d,
                          input string tag, input bit pulse);
        int lat;
        int busy_low;
        logic [31:0] exp;
        exp = ref_y(o, x, d);
        @(negedge clk);
        op = o; a = x; b = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_low = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_low++;
            if (pulse && lat == 4) begin start = 1'b1; a = 32'd1; b = 32'd1; end
            if (pulse && lat == 5) start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, ref_lat(o, x, d));
        check({tag, "_busy"}, busy_low, 0);
        check({tag, "_y"}, y, exp);
        @(posedge clk); #1;
        check({tag, "_pulse"}, done, 1'b0);
        check({tag, "_hold"}, y, exp);
    endtask

    initial begin
        int gap;
        int wait_cnt;
        int done_seen;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_y", y, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        run_op(2'b01, 32'd100, 32'd7, "divu_100_7", 1'b0);
        run_op(2'b11, 32'd100, 32'd7, "remu_100_7", 1'b0);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2", 1'b0);
        run_op(2'b01, 32'd5, 32'd0, "divu_by0", 1'b0);
        run_op(2'b11, 32'd5, 32'd0, "remu_by0", 1'b0);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd0, "div_by0", 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, "rem_by0", 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1'b0);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big", 1'b0);
        run_op(2'b01, 32'd100, 32'd7, "divu_ignore_start", 1'b1);

        // reset in the middle of a run
        @(negedge clk);
        op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_y", y, 32'd0);
        @(negedge clk) rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        run_op(2'b01, 32'd100, 32'd7, "after_rst", 1'b0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = 32'hFFFF_FFFF;
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(ro, ra, rb, $sformatf("rand%0d", i), 1'b0);
        end

        // start held high: back-to-back with no idle cycle between operations
        ra = $urandom;
        rb = ($urandom >> 20) | 32'd1;
        @(negedge clk);
        op = 2'b01; a = ra; b = rb; start = 1'b1;
        wait_cnt = 0;
        while (!done && wait_cnt < 200) begin @(posedge clk); #1; wait_cnt++; end
        check("chain_first_lat", wait_cnt, 34);
        check("chain_first_y", y, ref_y(2'b01, ra, rb));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            gap = 0;
            while (!done && gap < 200) begin gap++; @(posedge clk); #1; end
            check($sformatf("chain_gap%0d", k), gap, 33);
            check($sformatf("chain_y%0d", k), y, ref_y(2'b01, ra, rb));
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("chain_stop", done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
